// File: rtl/chip_if.sv
// Chip port bundle for the emulator.
// Purpose : groups every chip pin except clk/rst so the driver and the
//           emulator share one definition of the pin set.
// Signals : CBL/CSL write-1/write-0 select, CBLEN bitline enable,
//           CWL wordline write pulse, load_mem programming mode,
//           read_1/read_8 read commands, inference stream enable,
//           load_seed seed load, read_out output enable, stoch_log
//           stochastic AND mode, addr_full_row/addr_full_col cell
//           address (low nibble used), seeds LFSR seed, bit_out result.
// Modports: master drives the commands and reads bit_out; slave is the
//           emulator side.
interface chip_if;
  logic       CBL;
  logic       CSL;
  logic       CBLEN;
  logic       CWL;
  logic       load_mem;
  logic       read_1;
  logic       read_8;
  logic       inference;
  logic       load_seed;
  logic       read_out;
  logic       stoch_log;
  logic [7:0] addr_full_row;
  logic [7:0] addr_full_col;
  logic [7:0] seeds;
  logic [3:0] bit_out;

  modport master (
    output CBL, CSL, CBLEN, CWL, load_mem, read_1, read_8, inference,
           load_seed, read_out, stoch_log, addr_full_row, addr_full_col, seeds,
    input  bit_out
  );

  modport slave (
    input  CBL, CSL, CBLEN, CWL, load_mem, read_1, read_8, inference,
           load_seed, read_out, stoch_log, addr_full_row, addr_full_col, seeds,
    output bit_out
  );
endinterface

// File: rtl/chip_emulator.sv
// Behavioural emulator of a small 1-bit memory array chip with an
// 8-bit Fibonacci LFSR used for stochastic in-memory inference.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears cells, state, LFSR)
//   bus  - chip_if.slave: command/address/seed inputs, bit_out result
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | accepting commands; bit_out returns to 0 with no command
// S_READ8_B | second beat of read_8 pending; all commands ignored
// S_INFER   | streaming inference; LFSR advances every accepted edge
module chip_emulator #(
  parameter int         ROWS      = 16,
  parameter int         COLS      = 16,
  parameter logic [7:0] LFSR_INIT = 8'h01
) (
  input logic   clk,
  input logic   rst,
  chip_if.slave bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ8_B = 2'd1,
    S_INFER   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [COLS-1:0] cells [ROWS];
  logic [7:0]      lfsr;
  logic [7:0]      lfsr_d;
  logic [7:0]      lfsr_adv;
  logic [3:0]      lat_row;
  logic [3:0]      lat_col;
  logic [3:0]      bit_out_q;
  logic [3:0]      beat;
  logic            wr_en;
  logic            wr_val;
  logic            lat_en;
  logic [3:0]      row;
  logic [3:0]      col;
  logic            unused_addr_hi;

  assign row = bus.addr_full_row[3:0];
  assign col = bus.addr_full_col[3:0];
  // Upper address bits are don't-care on this chip.
  assign unused_addr_hi = &{1'b0, bus.addr_full_row[7:4], bus.addr_full_col[7:4]};

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Column indices wrap around the row.
  function automatic logic cell_at(input logic [3:0] r, input logic [3:0] c, input int k);
    int ci;
    ci = (int'(c) + k) % COLS;
    return cells[RW'(r)][CW'(ci)];
  endfunction

  function automatic logic [3:0] lanes(input logic [3:0] r, input logic [3:0] c, input int base);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) begin
      v[k] = cell_at(r, c, base + k);
    end
    return v;
  endfunction

  assign lfsr_adv = lfsr_step(lfsr);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; priority load_seed > load_mem > read_8 > read_1 > inference
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (bus.load_seed || bus.load_mem) begin
          next_state = S_IDLE;
        end else if (bus.read_8) begin
          next_state = S_READ8_B;
        end else if (bus.read_1) begin
          next_state = S_IDLE;
        end else if (bus.inference) begin
          next_state = S_INFER;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_READ8_B: next_state = S_IDLE;
      S_INFER: begin
        // Any higher-priority command, or inference dropping, ends the stream.
        if (!bus.load_seed && !bus.load_mem && !bus.read_8 && !bus.read_1 && bus.inference) begin
          next_state = S_INFER;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    beat   = 4'b0000;
    lfsr_d = lfsr;
    wr_en  = 1'b0;
    wr_val = 1'b0;
    lat_en = 1'b0;
    case (state)
      S_IDLE, S_INFER: begin
        if (bus.load_seed) begin
          lfsr_d = (bus.seeds == 8'h00) ? LFSR_INIT : bus.seeds;
        end else if (bus.load_mem) begin
          // Programming only from IDLE; CBL/CSL both set or both clear is a no-op.
          if (state == S_IDLE) begin
            wr_en  = bus.CWL & bus.CBLEN & (bus.CBL ^ bus.CSL);
            wr_val = bus.CBL;
          end
        end else if (bus.read_8) begin
          if (state == S_IDLE) begin
            beat   = lanes(row, col, 0);
            lat_en = 1'b1;
          end
        end else if (bus.read_1) begin
          if (state == S_IDLE) begin
            beat = {3'b000, cell_at(row, col, 0)};
          end
        end else if (bus.inference) begin
          lfsr_d = lfsr_adv;
          beat   = lanes(row, col, 0) & (bus.stoch_log ? lfsr_adv[3:0] : 4'b1111);
        end
      end
      S_READ8_B: beat = lanes(lat_row, lat_col, 4);
      default: beat = 4'b0000;
    endcase
  end

  // Datapath registers; read_out only gates what reaches bit_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_out_q <= 4'b0000;
      lfsr      <= LFSR_INIT;
      lat_row   <= 4'd0;
      lat_col   <= 4'd0;
      for (int i = 0; i < ROWS; i++) begin
        cells[i] <= '0;
      end
    end else begin
      bit_out_q <= bus.read_out ? beat : 4'b0000;
      lfsr      <= lfsr_d;
      if (lat_en) begin
        lat_row <= row;
        lat_col <= col;
      end
      if (wr_en) begin
        cells[RW'(row)][CW'(col)] <= wr_val;
      end
    end
  end

  assign bus.bit_out = bit_out_q;

endmodule
